// File: rtl/busca_instrucao.sv
// ============================================================================
// busca_instrucao -- instruction-fetch unit: PC, IR and the req/ack fetch FSM
// Rev 1.0
// ============================================================================
`default_nettype none

module busca_instrucao #(
  parameter int PC_WIDTH    = 8,
  parameter int INSTR_WIDTH = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  output logic                   mem_req,
  output logic [PC_WIDTH-1:0]    mem_addr,
  input  logic                   mem_ack,
  input  logic [INSTR_WIDTH-1:0] mem_data,
  input  logic                   EscCP,
  input  logic                   EscCondCP,
  input  logic [1:0]             FonteCP,
  input  logic                   zero,
  output logic [3:0]             opcode,
  output logic [3:0]             rd,
  output logic [3:0]             rs,
  output logic [3:0]             rt,
  output logic [7:0]             imm,
  output logic                   instr_valida,
  output logic [PC_WIDTH-1:0]    pc,
  output logic                   parado
);

  localparam logic [1:0] BUSCA      = 2'd0;
  localparam logic [1:0] DECODIFICA = 2'd1;
  localparam logic [1:0] EXECUTA    = 2'd2;
  localparam logic [1:0] PARADO     = 2'd3;

  localparam logic [3:0] OP_HALT = 4'd15;
  localparam int         EXT_W   = (PC_WIDTH > 8) ? PC_WIDTH : 8;

  logic [1:0]             state_q, state_d;
  logic [PC_WIDTH-1:0]    pc_q, pc_d;
  logic [INSTR_WIDTH-1:0] ir_q, ir_d;
  logic                   mem_req_q, mem_req_d;

  logic [EXT_W-1:0]       imm_sx;
  logic [EXT_W-1:0]       imm_zx;
  logic [PC_WIDTH-1:0]    pc_seq;

  always_comb begin
    imm_sx  = EXT_W'($signed(ir_q[7:0]));
    imm_zx  = EXT_W'(ir_q[7:0]);
    pc_seq  = pc_q + PC_WIDTH'(1);
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;

    case (state_q)
      // An ack only counts once the request is actually on the bus.
      BUSCA: begin
        if (mem_req_q && mem_ack) begin
          ir_d    = mem_data;
          state_d = DECODIFICA;
        end
      end
      DECODIFICA: begin
        state_d = (ir_q[15:12] == OP_HALT) ? PARADO : EXECUTA;
      end
      EXECUTA: begin
        if (EscCP) begin
          state_d = BUSCA;
          if (FonteCP == 2'b10)
            pc_d = imm_zx[PC_WIDTH-1:0];
          else if (FonteCP == 2'b01 && EscCondCP && zero)
            pc_d = pc_seq + imm_sx[PC_WIDTH-1:0];
          else
            pc_d = pc_seq;
        end
      end
      PARADO:  state_d = PARADO;
      default: state_d = BUSCA;
    endcase

    // Registered so the request is low during reset and rises on the first edge after it.
    mem_req_d = (state_d == BUSCA);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= BUSCA;
      pc_q      <= '0;
      ir_q      <= '0;
      mem_req_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      ir_q      <= ir_d;
      mem_req_q <= mem_req_d;
    end
  end

  assign mem_req      = mem_req_q;
  assign mem_addr     = pc_q;
  assign pc           = pc_q;
  assign opcode       = ir_q[15:12];
  assign rd           = ir_q[11:8];
  assign rs           = ir_q[7:4];
  assign rt           = ir_q[3:0];
  assign imm          = ir_q[7:0];
  assign instr_valida = (state_q == DECODIFICA);
  assign parado       = (state_q == PARADO);

endmodule

`default_nettype wire

// File: doc/busca_instrucao.md
# busca_instrucao

Instruction-fetch unit of the multicycle processor: the producer side of the opcode/control handshake. It holds the program counter and fetches instructions from instruction memory with a req/ack handshake. It latches each instruction into the instruction register and presents opcode and fields to the control unit. It then waits for the control unit's PC-write strobe and updates the PC according to the selected PC source.

## Interface
- PC_WIDTH, 8: program counter and memory address width.
- INSTR_WIDTH, 16: instruction width; format fixed as opcode[15:12], rd[11:8], rs[7:4], rt[3:0], imm[7:0].
- clk  in  1  system clock, all state on rising edge.
- rst  in  1  reset, asynchronous, active-high.
- mem_req  out  1  fetch request to instruction memory.
- mem_addr  out  PC_WIDTH  fetch address (= pc while mem_req high).
- mem_ack  in  1  memory has valid mem_data this cycle.
- mem_data  in  INSTR_WIDTH  instruction word.
- EscCP  in  1  PC write strobe from control.
- EscCondCP  in  1  conditional PC write (branch) from control.
- FonteCP  in  2  PC source: 00 sequential, 01 branch, 10 jump, 11 sequential.
- zero  in  1  ALU zero flag from datapath, branch condition.
- opcode  out  4  IR[15:12].
- rd, rs, rt  out  4 each  IR register fields.
- imm  out  8  IR[7:0].
- instr_valida  out  1  one-cycle pulse: new instruction available in IR.
- pc  out  PC_WIDTH  current program counter.
- parado  out  1  halted (opcode 4'd15 executed).

## Operation
- States: BUSCA, DECODIFICA, EXECUTA, PARADO.
- BUSCA: mem_req=1, mem_addr=pc. mem_req is held until mem_ack is sampled high. On the ack edge: IR <= mem_data, go to DECODIFICA.
- DECODIFICA: instr_valida=1 for exactly this cycle. If opcode==4'd15, go to PARADO; otherwise go to EXECUTA.
- EXECUTA: wait for EscCP==1 sampled at a rising edge. On that edge, update pc and go to BUSCA.
- PC update in EXECUTA:
  - FonteCP 10: pc <= {zero-extend imm} truncated to PC_WIDTH.
  - FonteCP 01 with EscCondCP=1 and zero=1: pc <= pc + 1 + sign-extend(imm).
  - All other cases, including 01 with zero=0, 01 with EscCondCP=0, and 11: pc <= pc + 1.
  - Arithmetic is modulo 2^PC_WIDTH; wrap-around from max to 0 is legal and silent.
- PARADO: terminal state. mem_req=0, parado=1. EscCP is ignored. Only rst exits.
- Outputs opcode/rd/rs/rt/imm are driven combinationally from IR. They stay stable from the IR latch until the next IR latch, so control sees a constant opcode for the whole instruction.
- Ignored inputs:
  - mem_ack outside BUSCA.
  - EscCP/EscCondCP/FonteCP outside EXECUTA.
  - mem_data when mem_ack=0.

## Timing
- Reset values: pc=0, IR=0 (opcode=0, rd=rs=rt=0, imm=0), mem_req=0, instr_valida=0, parado=0, state=BUSCA.
- Reset asserted mid-operation (any state, including mid-handshake): mem_req drops immediately; everything returns to reset values.
- First rising edge after rst deassert: mem_req=1, mem_addr=0.
- Memory may ack in the same cycle as req. Minimum instruction period is 3 cycles:
  - BUSCA with immediate ack.
  - DECODIFICA.
  - EXECUTA with EscCP already high.
- Each mem_ack wait cycle adds 1 cycle. Each cycle in EXECUTA without EscCP adds 1 cycle.
- instr_valida rises the cycle after the ack edge. pc changes on the EscCP edge. The new mem_addr is visible the cycle after that edge.
- mem_addr is stable for the entire duration of mem_req.

## Test plan
- Reset, then memory acks immediately with 16'h1234 at addr 0 and EscCP=1 is held:
  - Required: opcode=1, rd=2, rs=3, rt=4; instr_valida pulses once.
  - Required: pc becomes 1; next mem_req at addr 1.
  - Required: 3-cycle period per instruction.
- mem_ack delayed 4 cycles:
  - Required: mem_req and mem_addr stay constant.
  - Required: IR unchanged until the ack edge.
  - Required: a spurious EscCP during the wait leaves pc unchanged.
- Jump, IR=16'hB0F0, FonteCP=10, EscCP=1: pc=8'hF0.
- Branch at pc=5, IR=16'hC0FD (imm=-3), FonteCP=01, EscCondCP=1:
  - zero=1: pc=3.
  - zero=0: pc=6.
- pc=8'hFF, sequential advance: pc=0.
- IR=16'hF000: parado=1 and mem_req stays 0 for 20 cycles regardless of EscCP. rst mid-BUSCA: mem_req falls asynchronously, pc=0.
